bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Bus master interface that sits directly downstream of the transaction controller.
- Accepts one command per `enable` pulse: 14-bit address, 8-bit write data, and a read/write flag.
- Arbitrates for the shared serial bus, then shifts address and write data out bit-serially, MSB first, and shifts read data back in.
- Reports `m_request` (busy), `done`, `error` and `data_out`. One instance is used per master (m1, m2).

Parameters:
- ADDR_WIDTH, 14, command address width; upper 2 bits are the slave select, lower 12 bits are the slave-local address.
- DATA_WIDTH, 8, data width.
- TIMEOUT, 16, cycles to wait for a slave response before aborting.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  command strobe from the controller; sampled only in IDLE.
- read_en  in  1  1 = read, 0 = write; latched with `enable`.
- addr_in  in  ADDR_WIDTH  command address; latched with `enable`.
- data_in  in  DATA_WIDTH  write data; latched with `enable`.
- m_request  out  1  high from the cycle after command acceptance until DONE/ERR completes.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on timeout abort.
- data_out  out  DATA_WIDTH  last successfully read byte.
- bus_req  out  1  request to the bus arbiter.
- bus_grant  in  1  grant from the arbiter.
- bus_valid  out  1  high while `bus_out` carries an address or write-data bit.
- bus_mode  out  1  copy of the latched `read_en`, valid whenever `bus_valid` = 1.
- bus_out  out  1  serial address/data bit.
- slave_ack  in  1  slave write acknowledge.
- bus_in  in  1  serial read data bit from the slave.
- bus_in_valid  in  1  `bus_in` qualifier.

Behaviour:
- All outputs are registered.
- Reset (`reset` = 0, asynchronous): state = IDLE; every output = 0, including `data_out`; bit counter and timeout counter = 0. Asserting reset mid-transaction aborts immediately with no `done`/`error` pulse.
- States: IDLE, REQ, ADDR, WDATA, WACK, RDATA, DONE, ERR.
- IDLE:
  - On a posedge with `enable` = 1: latch `addr_in`, `data_in`, `read_en`; go to REQ.
  - In REQ, `bus_req` = 1 and `m_request` = 1.
  - `enable` outside IDLE is ignored (no queuing).
- REQ:
  - Hold `bus_req`; `bus_valid` = 0.
  - On a posedge with `bus_grant` = 1, go to ADDR. On that same edge load `bus_valid` = 1, `bus_out` = addr[13], bit count = 0.
- ADDR:
  - One bit per cycle, MSB first, for 14 cycles with `bus_valid` = 1.
  - After bit 0: write → WDATA, with `bus_out` = data[7] loaded on the same edge; read → RDATA, with `bus_valid` = 0.
- WDATA: 8 cycles, MSB first; then WACK with `bus_valid` = 0.
- Grant loss: if `bus_grant` = 0 at any posedge in ADDR or WDATA, drop `bus_valid` and return to REQ. The transfer restarts from address bit 13 on re-grant. `bus_req` stays asserted and the latched command is kept.
- WACK:
  - `slave_ack` = 1 → DONE.
  - Otherwise increment the timeout counter; at TIMEOUT → ERR.
- RDATA:
  - On each posedge with `bus_in_valid` = 1, shift `bus_in` into the shift register LSB side (first received bit ends up as the MSB) and clear the timeout counter.
  - After the 8th valid bit → DONE.
  - A cycle without `bus_in_valid` increments the timeout counter; at TIMEOUT → ERR.
  - Grant is not checked in WACK or RDATA.
- DONE (1 cycle):
  - `done` = 1; `bus_req` = 0; `m_request` = 0.
  - Read: `data_out` = shift register. Write: `data_out` unchanged.
  - Next state IDLE. A new `enable` is accepted in the following IDLE cycle.
- ERR (1 cycle): `error` = 1; `bus_req` = 0; `m_request` = 0; `data_out` unchanged; next state IDLE.
- Latency:
  - Write, immediate grant and ack: 1 (REQ) + 14 + 8 + 1 (WACK) + 1 (DONE) = 25 cycles after the `enable` edge.
  - Read: 1 + 14 + (cycles until the 8th valid bit) + 1.
- The timeout counter resets on every state entry. `bus_mode` = 0 whenever `bus_valid` = 0.

Test Plan:
- Write addr 1001 data 101, `bus_grant` and `slave_ack` tied 1 → `bus_out` stream 00001111101001 then 01100101 with `bus_valid` high for 22 cycles and `bus_mode` = 0; `done` pulse 25 cycles after `enable`; `m_request` then low.
- Read addr 5097, slave returns 01100101 on `bus_in_valid` with 2 idle gaps → address stream 01001111101001, `bus_mode` = 1; `data_out` = 101 at `done`.
- `bus_grant` withheld 5 cycles, then asserted, then dropped during the 7th address bit for 3 cycles → `bus_valid` = 0 while ungranted; full 14-bit address resent from bit 13; transaction completes with `done`.
- Write with `slave_ack` never asserted → `error` pulse after 16 WACK cycles; no `done`; `data_out` unchanged; `bus_req` = 0.
- `enable` pulsed again with different addr/data while busy → ignored; the original transaction completes unchanged; a third `enable` in the cycle after DONE is accepted.
- `reset` asserted low asynchronously mid-WDATA → all outputs 0 immediately; after release, a new write completes normally.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: arbitrated bit-serial bus master; shifts address/write data out MSB first and read data in.
module bus_master_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  m_request,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  bus_valid,
  output logic                  bus_mode,
  output logic                  bus_out,
  input  logic                  slave_ack,
  input  logic                  bus_in,
  input  logic                  bus_in_valid
);
  typedef enum logic [2:0] {IDLE, REQ, ADDR, WDATA, WACK, RDATA, DONE, ERR} state_t;
  localparam int CW = $clog2(ADDR_WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = ADDR_WIDTH - DATA_WIDTH;
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rd_q;
  // tx_sr holds the bit currently on bus_out at its MSB; write data is left-aligned
  logic [ADDR_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [CW-1:0]         bit_cnt;
  logic [TW-1:0]         tmo_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      m_request <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      data_out  <= '0;
      bus_req   <= 1'b0;
      bus_valid <= 1'b0;
      bus_mode  <= 1'b0;
      bus_out   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          addr_q    <= addr_in;
          data_q    <= data_in;
          rd_q      <= read_en;
          bus_req   <= 1'b1;
          m_request <= 1'b1;
          tmo_cnt   <= '0;
          state     <= REQ;
        end
        REQ: if (bus_grant) begin
          state     <= ADDR;
          bus_valid <= 1'b1;
          bus_mode  <= rd_q;
          tx_sr     <= addr_q;
          bus_out   <= addr_q[ADDR_WIDTH-1];
          bit_cnt   <= '0;
          tmo_cnt   <= '0;
        end
        ADDR, WDATA: begin
          // grant loss restarts the whole transfer from address MSB
          if (!bus_grant) begin
            state     <= REQ;
            bus_valid <= 1'b0;
            bus_mode  <= 1'b0;
            bus_out   <= 1'b0;
            tmo_cnt   <= '0;
          end else if (state == ADDR && bit_cnt == CW'(ADDR_WIDTH - 1)) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
            if (rd_q) begin
              state     <= RDATA;
              bus_valid <= 1'b0;
              bus_mode  <= 1'b0;
              bus_out   <= 1'b0;
            end else begin
              state   <= WDATA;
              tx_sr   <= {data_q, {PW{1'b0}}};
              bus_out <= data_q[DATA_WIDTH-1];
            end
          end else if (state == WDATA && bit_cnt == CW'(DATA_WIDTH - 1)) begin
            state     <= WACK;
            bus_valid <= 1'b0;
            bus_mode  <= 1'b0;
            bus_out   <= 1'b0;
            tmo_cnt   <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
            tx_sr   <= tx_sr << 1;
            bus_out <= tx_sr[ADDR_WIDTH-2];
          end
        end
        WACK: begin
          if (slave_ack) begin
            state     <= DONE;
            done      <= 1'b1;
            bus_req   <= 1'b0;
            m_request <= 1'b0;
            tmo_cnt   <= '0;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state     <= ERR;
            error     <= 1'b1;
            bus_req   <= 1'b0;
            m_request <= 1'b0;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RDATA: begin
          if (bus_in_valid) begin
            rx_sr   <= {rx_sr[DATA_WIDTH-2:0], bus_in};
            tmo_cnt <= '0;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              state     <= DONE;
              done      <= 1'b1;
              bus_req   <= 1'b0;
              m_request <= 1'b0;
              data_out  <= {rx_sr[DATA_WIDTH-2:0], bus_in};
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state     <= ERR;
            error     <= 1'b1;
            bus_req   <= 1'b0;
            m_request <= 1'b0;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DONE, ERR: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed checks of the serial bus master against hand-computed streams and latencies.
module tb_bus_master_port;
  logic       clk = 1'b0;
  logic       reset, enable, read_en, bus_grant, slave_ack, bus_in, bus_in_valid;
  logic [13:0] addr_in;
  logic [7:0]  data_in, data_out;
  logic       m_request, done, error, bus_req, bus_valid, bus_mode, bus_out;
  int         total = 0, bad = 0;
  logic [63:0] stream;
  int         nvalid, ncyc, mode_bad, req_bad;
  bit         got_done, got_err;
  logic [99:0] gnt_sched;
  bit         rv[16], rb[16];

  bus_master_port dut (
    .clk(clk), .reset(reset), .enable(enable), .read_en(read_en),
    .addr_in(addr_in), .data_in(data_in), .m_request(m_request), .done(done),
    .error(error), .data_out(data_out), .bus_req(bus_req), .bus_grant(bus_grant),
    .bus_valid(bus_valid), .bus_mode(bus_mode), .bus_out(bus_out),
    .slave_ack(slave_ack), .bus_in(bus_in), .bus_in_valid(bus_in_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ncyc counts posedges including the enable edge, so it equals the cycle in which done/error is high
  task automatic run(input bit rd, input logic [13:0] a, input logic [7:0] d, input int busy_at);
    int j;
    j = 0;
    enable = 1'b1; read_en = rd; addr_in = a; data_in = d;
    stream = '0; nvalid = 0; ncyc = 0; mode_bad = 0; req_bad = 0;
    got_done = 1'b0; got_err = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus_grant = gnt_sched[k];
      tick();
      enable = (k == busy_at);
      if (k == busy_at) begin
        addr_in = ~a; data_in = ~d; read_en = ~rd;
      end
      if (bus_valid) begin
        stream = {stream[62:0], bus_out};
        nvalid++;
        if (bus_mode !== rd) mode_bad++;
      end else if (bus_mode !== 1'b0) mode_bad++;
      if (rd && nvalid >= 14 && !bus_valid && j < 16) begin
        bus_in_valid = rv[j]; bus_in = rb[j]; j++;
      end else begin
        bus_in_valid = 1'b0; bus_in = 1'b0;
      end
      if (done) begin got_done = 1'b1; ncyc = k + 1; break; end
      if (error) begin got_err = 1'b1; ncyc = k + 1; break; end
      if (bus_req !== 1'b1 || m_request !== 1'b1) req_bad++;
    end
    enable = 1'b0; bus_in_valid = 1'b0; bus_grant = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; read_en = 1'b0; addr_in = '0; data_in = '0;
    bus_grant = 1'b1; slave_ack = 1'b1; bus_in = 1'b0; bus_in_valid = 1'b0;
    gnt_sched = '1;
    rv = '{1,1,0,1,1,1,0,1,1,1,0,0,0,0,0,0};
    rb = '{0,1,0,1,0,0,0,1,0,1,0,0,0,0,0,0};
    repeat (2) tick();
    chk("reset_outputs", 64'({m_request, done, error, data_out, bus_req, bus_valid, bus_mode, bus_out}), 64'd0);
    @(negedge clk) reset = 1'b1;

    run(1'b0, 14'd1001, 8'd101, -1);
    chk("wr_stream", stream, 64'({14'b00001111101001, 8'b01100101}));
    chk("wr_nvalid", 64'(nvalid), 64'd22);
    chk("wr_latency", 64'(ncyc), 64'd25);
    chk("wr_mode", 64'(mode_bad), 64'd0);
    chk("wr_req_held", 64'(req_bad), 64'd0);
    tick();
    chk("wr_after_done", 64'({done, m_request, bus_req, data_out}), 64'd0);

    run(1'b1, 14'd5097, 8'h00, -1);
    chk("rd_stream", stream, 64'(14'b01001111101001));
    chk("rd_nvalid", 64'(nvalid), 64'd14);
    chk("rd_latency", 64'(ncyc), 64'd26);
    chk("rd_mode", 64'(mode_bad), 64'd0);
    chk("rd_data_out", 64'(data_out), 64'd101);
    tick();

    gnt_sched[5:1] = '0;
    gnt_sched[15:13] = '0;
    run(1'b0, 14'h2A5C, 8'hC3, -1);
    gnt_sched = '1;
    chk("gnt_stream", stream, 64'({7'b1010100, 14'b10101001011100, 8'hC3}));
    chk("gnt_nvalid", 64'(nvalid), 64'd29);
    chk("gnt_latency_done", 64'({got_done, 7'(ncyc)}), 64'({1'b1, 7'd40}));
    chk("gnt_req_held", 64'(req_bad), 64'd0);
    tick();

    slave_ack = 1'b0;
    run(1'b0, 14'h0155, 8'h3C, -1);
    chk("tmo_err_not_done", 64'({got_err, got_done}), 64'b10);
    chk("tmo_latency", 64'(ncyc), 64'd40);
    chk("tmo_outputs", 64'({bus_req, m_request, done, data_out}), 64'({3'b000, 8'd101}));
    tick();
    chk("tmo_pulse_end", 64'(error), 64'd0);
    slave_ack = 1'b1;

    run(1'b0, 14'h0F0F, 8'h5A, 8);
    chk("busy_stream", stream, 64'({14'h0F0F, 8'h5A}));
    chk("busy_latency", 64'(ncyc), 64'd25);
    tick();
    chk("busy_after_done", 64'({done, m_request, bus_req}), 64'd0);
    run(1'b0, 14'h3FFF, 8'h00, -1);
    chk("third_stream", stream, 64'({14'h3FFF, 8'h00}));
    chk("third_latency", 64'(ncyc), 64'd25);
    chk("third_data_out", 64'(data_out), 64'd101);
    tick();

    enable = 1'b1; read_en = 1'b0; addr_in = 14'h1111; data_in = 8'hAA;
    tick();
    enable = 1'b0;
    repeat (17) tick();
    chk("rst_pre_wdata", 64'({bus_valid, bus_req, m_request}), 64'b111);
    reset = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({m_request, done, error, data_out, bus_req, bus_valid, bus_mode, bus_out}), 64'd0);
    @(negedge clk) reset = 1'b1;
    run(1'b0, 14'h2222, 8'h81, -1);
    chk("rst_recover_stream", stream, 64'({14'h2222, 8'h81}));
    chk("rst_recover_latency", 64'(ncyc), 64'd25);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
